// File: rtl/player_projectile_ctrl.sv
// Projectile pool for the player ship: turns fire-button edges into upward shots,
// moves them on step pulses and retires them on hits or at the top of the screen.
module player_projectile_ctrl #(
    parameter int NUM_PROJ       = 2,
    parameter int SPEED          = 4,
    parameter int COOLDOWN_STEPS = 3
) (
    input  logic                   clk_master,
    input  logic                   rst,
    input  logic                   pulse_stepCycle,
    input  logic                   fire,
    input  logic                   playerAlive,
    input  logic [9:0]             playerX,
    input  logic [8:0]             playerY,
    input  logic [9:0]             playerW,
    input  logic [9:0]             projW,
    input  logic [8:0]             projH,
    input  logic [NUM_PROJ-1:0]    projHit,
    output logic [NUM_PROJ*10-1:0] projX,
    output logic [NUM_PROJ*9-1:0]  projY,
    output logic [NUM_PROJ-1:0]    projActive,
    output logic [7:0]             shotsFired
);

    localparam int              CD_W    = (COOLDOWN_STEPS > 0) ? $clog2(COOLDOWN_STEPS + 1) : 1;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_STEPS);
    localparam logic [8:0]      SPEED_Y = 9'(SPEED);

    logic [9:0]          x_q [NUM_PROJ];
    logic [9:0]          x_d [NUM_PROJ];
    logic [8:0]          y_q [NUM_PROJ];
    logic [8:0]          y_d [NUM_PROJ];
    logic [NUM_PROJ-1:0] active_q, active_d;
    logic [CD_W-1:0]     cooldown_q, cooldown_d;
    logic                pending_q, pending_d;
    logic                fire_prev_q, fire_prev_d;
    logic [7:0]          shots_q, shots_d;

    logic [NUM_PROJ-1:0] hit;
    logic [NUM_PROJ-1:0] free_slot;
    logic                fire_edge;
    logic                spawn;
    logic                placed;
    logic [9:0]          spawn_x;
    logic [8:0]          spawn_y;

    always_comb begin
        hit       = projHit & active_q;
        // A slot emptied by a hit this clock can be reused immediately; one leaving the top cannot.
        free_slot = ~active_q | hit;
        fire_edge = fire & ~fire_prev_q;
        spawn_x   = playerX + {1'b0, playerW[9:1]} - {1'b0, projW[9:1]};
        spawn_y   = playerY - projH;
        spawn     = pulse_stepCycle & pending_q & (cooldown_q == '0) & playerAlive
                    & (playerY >= projH) & (|free_slot);

        active_d = active_q;
        placed   = 1'b0;
        for (int i = 0; i < NUM_PROJ; i++) begin
            x_d[i] = x_q[i];
            y_d[i] = y_q[i];
            if (hit[i]) begin
                active_d[i] = 1'b0;
                x_d[i]      = '0;
                y_d[i]      = '0;
            end else if (pulse_stepCycle && active_q[i]) begin
                if (y_q[i] < SPEED_Y) begin
                    active_d[i] = 1'b0;
                    x_d[i]      = '0;
                    y_d[i]      = '0;
                end else begin
                    y_d[i] = y_q[i] - SPEED_Y;
                end
            end
            if (spawn && free_slot[i] && !placed) begin
                active_d[i] = 1'b1;
                x_d[i]      = spawn_x;
                y_d[i]      = spawn_y;
                placed      = 1'b1;
            end
        end

        cooldown_d = cooldown_q;
        if (spawn) begin
            cooldown_d = CD_LOAD;
        end else if (pulse_stepCycle && (cooldown_q != '0)) begin
            cooldown_d = cooldown_q - CD_W'(1);
        end

        shots_d = (spawn && (shots_q != 8'hFF)) ? shots_q + 8'd1 : shots_q;

        // A fresh edge survives a coinciding step so it is served on the next one.
        if (!playerAlive) begin
            pending_d = 1'b0;
        end else if (fire_edge) begin
            pending_d = 1'b1;
        end else if (pulse_stepCycle) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end

        fire_prev_d = fire;
    end

    always_ff @(posedge clk_master) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PROJ; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            active_q    <= '0;
            cooldown_q  <= '0;
            pending_q   <= 1'b0;
            fire_prev_q <= 1'b1;
            shots_q     <= '0;
        end else begin
            for (int i = 0; i < NUM_PROJ; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
            active_q    <= active_d;
            cooldown_q  <= cooldown_d;
            pending_q   <= pending_d;
            fire_prev_q <= fire_prev_d;
            shots_q     <= shots_d;
        end
    end

    for (genvar g = 0; g < NUM_PROJ; g++) begin : g_pack
        assign projX[10*g +: 10] = x_q[g];
        assign projY[9*g +: 9]   = y_q[g];
    end

    assign projActive = active_q;
    assign shotsFired = shots_q;

endmodule

// File: tb/tb_player_projectile_ctrl.sv
// Bench for player_projectile_ctrl: fixed vector table, hand-written corner
// sequences, saturation sweep and a randomized run against a behavioural model.
module tb_player_projectile_ctrl;

    localparam int NP = 2;
    localparam int SPEED = 4;
    localparam int CD = 3;

    logic           clk_master = 1'b0;
    logic           rst, pulse_stepCycle, fire, playerAlive;
    logic [9:0]     playerX, playerW, projW;
    logic [8:0]     playerY, projH;
    logic [NP-1:0]  projHit;
    logic [NP*10-1:0] projX;
    logic [NP*9-1:0]  projY;
    logic [NP-1:0]  projActive;
    logic [7:0]     shotsFired;

    int nvec = 0;
    int nerr = 0;

    // behavioural model state
    int m_act [NP];
    int m_x   [NP];
    int m_y   [NP];
    int m_cd, m_shots;
    bit m_pend, m_fprev;

    typedef struct {
        logic       f;
        logic       s;
        logic [1:0] h;
        logic [1:0] act;
        int         x0, y0, x1, y1, shots;
    } vec_t;
    vec_t tbl[$];

    always #5 clk_master = ~clk_master;

    player_projectile_ctrl #(.NUM_PROJ(NP), .SPEED(SPEED), .COOLDOWN_STEPS(CD)) dut (
        .clk_master(clk_master), .rst(rst), .pulse_stepCycle(pulse_stepCycle),
        .fire(fire), .playerAlive(playerAlive), .playerX(playerX), .playerY(playerY),
        .playerW(playerW), .projW(projW), .projH(projH), .projHit(projHit),
        .projX(projX), .projY(projY), .projActive(projActive), .shotsFired(shotsFired)
    );

    function automatic vec_t mk(logic f, logic s, logic [1:0] h, logic [1:0] act,
                                int x0, int y0, int x1, int y1, int sh);
        vec_t v;
        v.f = f; v.s = s; v.h = h; v.act = act;
        v.x0 = x0; v.y0 = y0; v.x1 = x1; v.y1 = y1; v.shots = sh;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clk();
        int  nact [NP];
        int  nx   [NP];
        int  ny   [NP];
        int  tgt;
        bit  do_spawn, edge_seen;
        if (!rst) begin
            for (int i = 0; i < NP; i++) begin
                m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
            end
            m_cd = 0; m_shots = 0; m_pend = 0; m_fprev = 1;
            return;
        end
        tgt = -1;
        for (int i = 0; i < NP; i++)
            if (tgt < 0 && (m_act[i] == 0 || projHit[i])) tgt = i;
        do_spawn = pulse_stepCycle && m_pend && m_cd == 0 && playerAlive
                   && int'(playerY) >= int'(projH) && tgt >= 0;
        for (int i = 0; i < NP; i++) begin
            nact[i] = m_act[i]; nx[i] = m_x[i]; ny[i] = m_y[i];
            if (m_act[i] != 0 && projHit[i]) begin
                nact[i] = 0; nx[i] = 0; ny[i] = 0;
            end else if (m_act[i] != 0 && pulse_stepCycle) begin
                if (m_y[i] < SPEED) begin
                    nact[i] = 0; nx[i] = 0; ny[i] = 0;
                end else begin
                    ny[i] = m_y[i] - SPEED;
                end
            end
        end
        if (do_spawn) begin
            nact[tgt] = 1;
            nx[tgt] = ((int'(playerX) + int'(playerW) / 2 - int'(projW) / 2) % 1024 + 1024) % 1024;
            ny[tgt] = int'(playerY) - int'(projH);
            m_shots = (m_shots < 255) ? m_shots + 1 : 255;
            m_cd = CD;
        end else if (pulse_stepCycle && m_cd > 0) begin
            m_cd = m_cd - 1;
        end
        edge_seen = fire && !m_fprev;
        if (!playerAlive) m_pend = 0;
        else if (edge_seen) m_pend = 1;
        else if (pulse_stepCycle) m_pend = 0;
        m_fprev = fire;
        for (int i = 0; i < NP; i++) begin
            m_act[i] = nact[i]; m_x[i] = nx[i]; m_y[i] = ny[i];
        end
    endtask

    task automatic apply(input logic r, input logic f, input logic s, input logic a,
                         input logic [NP-1:0] h);
        rst = r; fire = f; pulse_stepCycle = s; playerAlive = a; projHit = h;
        model_clk();
        @(posedge clk_master);
        #1;
    endtask

    task automatic check_model();
        int ea;
        ea = 0;
        for (int i = 0; i < NP; i++) begin
            if (m_act[i] != 0) ea = ea | (1 << i);
            chk($sformatf("model_x%0d", i), int'(projX[10*i +: 10]), m_x[i]);
            chk($sformatf("model_y%0d", i), int'(projY[9*i +: 9]), m_y[i]);
        end
        chk("model_active", int'(projActive), ea);
        chk("model_shots", int'(shotsFired), m_shots);
    endtask

    task automatic chk_slot0(input string tag, input int act, input int x0, input int y0,
                             input int sh);
        chk({tag, "_active"}, int'(projActive), act);
        chk({tag, "_x0"}, int'(projX[9:0]), x0);
        chk({tag, "_y0"}, int'(projY[8:0]), y0);
        chk({tag, "_shots"}, int'(shotsFired), sh);
    endtask

    initial begin
        rst = 0; fire = 0; pulse_stepCycle = 0; playerAlive = 1; projHit = '0;
        playerX = 10'd300; playerW = 10'd40; projW = 10'd4; playerY = 9'd440; projH = 9'd8;

        // table: fire/step/hit -> active, x0, y0, x1, y1, shots
        tbl.push_back(mk(1, 0, 2'b00, 2'b00,   0,   0,   0,   0, 0));
        tbl.push_back(mk(0, 1, 2'b00, 2'b01, 318, 432,   0,   0, 1));
        tbl.push_back(mk(0, 1, 2'b00, 2'b01, 318, 428,   0,   0, 1));
        tbl.push_back(mk(0, 1, 2'b00, 2'b01, 318, 424,   0,   0, 1));
        tbl.push_back(mk(0, 1, 2'b00, 2'b01, 318, 420,   0,   0, 1));
        tbl.push_back(mk(1, 0, 2'b00, 2'b01, 318, 420,   0,   0, 1));
        tbl.push_back(mk(0, 1, 2'b00, 2'b11, 318, 416, 318, 432, 2));
        tbl.push_back(mk(1, 0, 2'b00, 2'b11, 318, 416, 318, 432, 2));
        tbl.push_back(mk(0, 1, 2'b00, 2'b11, 318, 412, 318, 428, 2));
        tbl.push_back(mk(0, 1, 2'b00, 2'b11, 318, 408, 318, 424, 2));
        tbl.push_back(mk(0, 1, 2'b00, 2'b11, 318, 404, 318, 420, 2));
        tbl.push_back(mk(1, 0, 2'b00, 2'b11, 318, 404, 318, 420, 2));
        tbl.push_back(mk(0, 1, 2'b00, 2'b11, 318, 400, 318, 416, 2));
        tbl.push_back(mk(0, 0, 2'b01, 2'b10,   0,   0, 318, 416, 2));
        tbl.push_back(mk(0, 0, 2'b01, 2'b10,   0,   0, 318, 416, 2));
        tbl.push_back(mk(0, 0, 2'b10, 2'b00,   0,   0,   0,   0, 2));
        tbl.push_back(mk(1, 0, 2'b00, 2'b00,   0,   0,   0,   0, 2));
        tbl.push_back(mk(0, 1, 2'b00, 2'b01, 318, 432,   0,   0, 3));
        tbl.push_back(mk(0, 1, 2'b00, 2'b01, 318, 428,   0,   0, 3));
        tbl.push_back(mk(0, 1, 2'b00, 2'b01, 318, 424,   0,   0, 3));
        tbl.push_back(mk(0, 1, 2'b00, 2'b01, 318, 420,   0,   0, 3));
        tbl.push_back(mk(1, 0, 2'b00, 2'b01, 318, 420,   0,   0, 3));
        tbl.push_back(mk(0, 1, 2'b00, 2'b11, 318, 416, 318, 432, 4));
        tbl.push_back(mk(0, 1, 2'b00, 2'b11, 318, 412, 318, 428, 4));
        tbl.push_back(mk(0, 1, 2'b00, 2'b11, 318, 408, 318, 424, 4));
        tbl.push_back(mk(0, 1, 2'b00, 2'b11, 318, 404, 318, 420, 4));
        tbl.push_back(mk(1, 0, 2'b00, 2'b11, 318, 404, 318, 420, 4));
        tbl.push_back(mk(0, 1, 2'b01, 2'b11, 318, 432, 318, 416, 5));

        apply(0, 0, 0, 1, 2'b00);
        apply(0, 0, 0, 1, 2'b00);
        chk("reset_active", int'(projActive), 0);
        chk("reset_projX", int'(projX), 0);
        chk("reset_projY", int'(projY), 0);
        chk("reset_shots", int'(shotsFired), 0);
        apply(1, 0, 0, 1, 2'b00);

        for (int k = 0; k < tbl.size(); k++) begin
            apply(1, tbl[k].f, tbl[k].s, 1, tbl[k].h);
            chk($sformatf("tbl%0d_active", k), int'(projActive), int'(tbl[k].act));
            chk($sformatf("tbl%0d_x0", k), int'(projX[9:0]), tbl[k].x0);
            chk($sformatf("tbl%0d_y0", k), int'(projY[8:0]), tbl[k].y0);
            chk($sformatf("tbl%0d_x1", k), int'(projX[19:10]), tbl[k].x1);
            chk($sformatf("tbl%0d_y1", k), int'(projY[17:9]), tbl[k].y1);
            chk($sformatf("tbl%0d_shots", k), int'(shotsFired), tbl[k].shots);
        end

        // top exit: a shot spawned at Y=2 leaves on the very next step
        apply(1, 0, 0, 1, 2'b11);
        chk("top_cleared", int'(projActive), 0);
        for (int k = 0; k < 3; k++) apply(1, 0, 1, 1, 2'b00);
        playerY = 9'd10;
        apply(1, 1, 0, 1, 2'b00);
        apply(1, 0, 1, 1, 2'b00);
        chk_slot0("top_spawn", 1, 318, 2, 6);
        apply(1, 0, 1, 1, 2'b00);
        chk_slot0("top_exit", 0, 0, 0, 6);

        // fire held through reset must not fire until released and pressed again
        playerY = 9'd440;
        apply(0, 1, 0, 1, 2'b00);
        chk_slot0("held_rst", 0, 0, 0, 0);
        apply(1, 1, 0, 1, 2'b00);
        apply(1, 1, 1, 1, 2'b00);
        chk_slot0("held_nofire", 0, 0, 0, 0);
        apply(1, 0, 0, 1, 2'b00);
        apply(1, 1, 0, 1, 2'b00);
        apply(1, 0, 1, 1, 2'b00);
        chk_slot0("repress", 1, 318, 432, 1);

        // reset with two shots in flight
        for (int k = 0; k < 3; k++) apply(1, 0, 1, 1, 2'b00);
        apply(1, 1, 0, 1, 2'b00);
        apply(1, 0, 1, 1, 2'b00);
        chk("two_inflight", int'(projActive), 3);
        apply(0, 0, 0, 1, 2'b00);
        chk("midrst_active", int'(projActive), 0);
        chk("midrst_projX", int'(projX), 0);
        chk("midrst_projY", int'(projY), 0);
        chk("midrst_shots", int'(shotsFired), 0);

        // dead player: edges ignored, in-flight shot keeps moving
        apply(1, 0, 0, 1, 2'b00);
        apply(1, 1, 0, 1, 2'b00);
        apply(1, 0, 1, 1, 2'b00);
        chk_slot0("dead_pre", 1, 318, 432, 1);
        for (int k = 0; k < 6; k++) begin
            apply(1, 1, 0, 0, 2'b00);
            apply(1, 0, 1, 0, 2'b00);
            chk_slot0($sformatf("dead%0d", k), 1, 318, 428 - 4 * k, 1);
        end
        apply(1, 0, 1, 1, 2'b00);
        chk_slot0("revive_nopend", 1, 318, 404, 1);

        // shot counter saturation
        apply(0, 0, 0, 1, 2'b00);
        apply(1, 0, 0, 1, 2'b00);
        for (int k = 0; k < 260; k++) begin
            apply(1, 0, 0, 1, 2'b11);
            apply(1, 1, 0, 1, 2'b00);
            apply(1, 0, 1, 1, 2'b00);
            for (int j = 0; j < 3; j++) apply(1, 0, 1, 1, 2'b00);
            chk($sformatf("sat%0d", k), int'(shotsFired), (k + 1 < 255) ? k + 1 : 255);
        end

        // randomized run against the model
        apply(0, 0, 0, 1, 2'b00);
        for (int n = 0; n < 3000; n++) begin
            logic r, f, s, a;
            logic [NP-1:0] h;
            if (n % 64 == 0) begin
                playerX = 10'($urandom_range(1023));
                playerW = 10'($urandom_range(120));
                projW   = 10'($urandom_range(16));
                playerY = 9'($urandom_range(479));
                projH   = 9'($urandom_range(40));
            end
            s = ($urandom_range(3) == 0);
            f = fire;
            if (!s && $urandom_range(2) == 0) f = ~fire;
            a = ($urandom_range(15) != 0);
            h = ($urandom_range(7) == 0) ? NP'($urandom_range(3)) : '0;
            r = ($urandom_range(499) != 0);
            apply(r, f, s, a, h);
            check_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
